data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Data-memory responder for the MA stage of the RV32IM pipeline; the target end of the CPU's DMEM request/BUSYWAIT interface.
- Accepts byte, halfword and word loads and stores.
- Stalls the CPU by holding BUSYWAIT for a fixed, parameterised access latency.
- Byte-addressed, little-endian, backed by an internal word array; sits beside the cpu top level in the system testbench.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the array; power of 2.
LATENCY, 5, cycles BUSYWAIT stays high per access; must be >= 1.

Ports:
CLK  input  1  clock, all state updates on rising edge
RST  input  1  synchronous, active-high reset
ADDRESS  input  32  byte address (CPU ALU result in MA)
WRITEDATA  input  32  store data, taken from its low bytes
READ  input  4  [3]=load enable, [2:0]=funct3 (000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU)
WRITE  input  3  [2]=store enable, [1:0]=size (00 SB, 01 SH, 10 SW)
READDATA  output  32  extended load result
BUSYWAIT  output  1  high while an access is pending; CPU freezes all stages
MISALIGNED  output  1  one-cycle pulse, high in DONE if the completed access was misaligned

Behaviour:
- Reset: state=IDLE, counter=0, READDATA=0, BUSYWAIT=0, MISALIGNED=0. Array contents are not cleared.
- A request exists when READ[3] | WRITE[2]. If both are set, the access is a store only and READDATA is unchanged.
- States are IDLE, WAIT and DONE.
- IDLE:
  - BUSYWAIT = request & ~RST (combinational).
  - On a request, latch ADDRESS, WRITEDATA, READ and WRITE. Go to DONE if LATENCY==1; otherwise go to WAIT with counter=1.
- WAIT:
  - BUSYWAIT=1. Counter increments each cycle.
  - When counter==LATENCY-1, go to DONE.
  - Input changes during WAIT are ignored; the latched request is used.
- Transition into DONE:
  - Store: write the enabled bytes into the array.
  - Load: register the extended result into READDATA.
- DONE:
  - BUSYWAIT=0 even though the same request is still on the inputs; the CPU advances on this edge.
  - Next state is always IDLE.
- Latency: BUSYWAIT is high for exactly LATENCY cycles per access. Back-to-back requests have one non-busy DONE cycle between them.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo the array size.
- Byte lane = addr[1:0]:
  - SB writes lane addr[1:0].
  - SH writes lanes {addr[1],0} and {addr[1],1}.
  - SW writes all four lanes.
- Loads:
  - LB/LBU select the byte at addr[1:0]; LH/LHU select the halfword at addr[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- Misalignment: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - The access is performed at the aligned-down address.
  - MISALIGNED pulses for the DONE cycle.
- Unsupported funct3 with READ[3]=1 (011, 110, 111): treated as LW.
- READDATA holds its value until the next load completes.
- RST asserted mid-access (in WAIT or DONE):
  - Return to IDLE; any pending store is abandoned and not written.
  - BUSYWAIT drops in the same cycle RST is high.

Decomposition:
- Shared package dmem_pkg holds:
  - load funct3 constants LB/LH/LW/LBU/LHU;
  - store size constants SB/SH/SW;
  - state encodings IDLE/WAIT/DONE;
  - field positions for the enable bits READ[3] and WRITE[2].
- The cpu control unit imports the same package.
- One sub-module, dmem_lane_align (combinational), does:
  - store byte-enable and data replication;
  - load lane select plus sign/zero extension;
  - misalignment detection.
- The FSM, counter and array live in data_memory_ctrl.

Test Plan:
- Reset then idle: RST for 2 cycles with no request → READDATA=0, BUSYWAIT=0, MISALIGNED=0.
- Word round trip, LATENCY=5: SW 0xDEADBEEF at 0x40 → BUSYWAIT high exactly 5 cycles, then low for 1. LW at 0x40 → READDATA=0xDEADBEEF in the DONE cycle.
- Byte/half extension: after the word above:
  - LB 0x43 → 0xFFFFFFDE
  - LBU 0x43 → 0x000000DE
  - LH 0x40 → 0xFFFFBEEF
  - LHU 0x42 → 0x0000DEAD
- Partial store: SB 0x12 at 0x41, then LW 0x40 → 0xDEAD12EF. SH 0x7777 at 0x42, then LW 0x40 → 0x777712EF.
- Misaligned and wrap:
  - LW at 0x43 → MISALIGNED pulses 1 cycle, READDATA=0x777712EF.
  - SW 0x11111111 at 0x440 (DEPTH_WORDS=256), then LW 0x40 → 0x11111111.
- Reset mid-store and LATENCY=1:
  - SW 0xCAFEF00D at 0x80 with RST in the 3rd busy cycle → BUSYWAIT=0 that cycle; a later LW 0x80 returns the old contents.
  - With LATENCY=1, each request gives BUSYWAIT high for exactly 1 cycle.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory request interface.
// The CPU control unit imports the same encodings.
package dmem_pkg;

  // Load funct3 encodings carried on READ[2:0]
  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  // Store size encodings carried on WRITE[1:0]
  localparam logic [1:0] SB = 2'b00;
  localparam logic [1:0] SH = 2'b01;
  localparam logic [1:0] SW = 2'b10;

  // Enable bit positions within READ and WRITE
  localparam int READ_EN_BIT  = 3;
  localparam int WRITE_EN_BIT = 2;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } dmem_state_t;

  // Widen a byte or halfword to 32 bits with sign or zero fill
  function automatic logic [31:0] extend_load(input logic [15:0] value,
                                              input logic       is_half,
                                              input logic       sign_ext);
    logic fill;
    if (is_half) begin
      fill = sign_ext & value[15];
      return {{16{fill}}, value};
    end else begin
      fill = sign_ext & value[7];
      return {{24{fill}}, value[7:0]};
    end
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the 32-bit word array and the CPU:
// store byte enables and data replication, load lane select with
// sign/zero extension, and misalignment detection.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [2:0]  load_funct3,
  input  logic [1:0]  store_size,
  input  logic        is_store,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lanes,
  output logic [31:0] load_data,
  output logic        misaligned
);

  logic [7:0]  byte_sel_s;
  logic [15:0] half_sel_s;

  // Pick the addressed byte and halfword out of the stored word
  always_comb begin
    byte_sel_s = rword[{addr_lo, 3'b000} +: 8];
    if (addr_lo[1]) begin
      half_sel_s = rword[31:16];
    end else begin
      half_sel_s = rword[15:0];
    end
  end

  // Decode access size into lanes, replicated data, load result and alignment
  always_comb begin
    byte_en     = 4'b0000;
    wdata_lanes = 32'h0000_0000;
    load_data   = 32'h0000_0000;
    misaligned  = 1'b0;
    if (is_store) begin
      case (store_size)
        SB: begin
          byte_en     = 4'b0001 << addr_lo;
          wdata_lanes = {4{wdata[7:0]}};
        end
        SH: begin
          // Odd halfword addresses fall back to the aligned-down halfword
          byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
          wdata_lanes = {2{wdata[15:0]}};
          misaligned  = addr_lo[0];
        end
        default: begin
          byte_en     = 4'b1111;
          wdata_lanes = wdata;
          misaligned  = |addr_lo;
        end
      endcase
    end else begin
      case (load_funct3)
        LB:  load_data = extend_load({8'h00, byte_sel_s}, 1'b0, 1'b1);
        LBU: load_data = extend_load({8'h00, byte_sel_s}, 1'b0, 1'b0);
        LH: begin
          load_data  = extend_load(half_sel_s, 1'b1, 1'b1);
          misaligned = addr_lo[0];
        end
        LHU: begin
          load_data  = extend_load(half_sel_s, 1'b1, 1'b0);
          misaligned = addr_lo[0];
        end
        default: begin
          // LW and the unsupported encodings all read the whole word
          load_data  = rword;
          misaligned = |addr_lo;
        end
      endcase
    end
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Data-memory responder for the MA stage: accepts byte/half/word loads
// and stores, holding BUSYWAIT for LATENCY cycles per access.
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 5
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] ADDRESS,
  input  logic [31:0] WRITEDATA,
  input  logic [3:0]  READ,
  input  logic [2:0]  WRITE,
  output logic [31:0] READDATA,
  output logic        BUSYWAIT,
  output logic        MISALIGNED
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);
  // With a single-cycle latency the WAIT state is skipped entirely
  localparam dmem_state_t AFTER_IDLE = (LATENCY == 1) ? DONE : WAIT;

  dmem_state_t       state_r, state_next_s;
  logic [CNT_W-1:0]  count_r;
  logic [IDX_W+1:0]  addr_r;
  logic [31:0]       wdata_r;
  logic [3:0]        read_r;
  logic [2:0]        write_r;
  logic [31:0]       readdata_r;
  logic              misaligned_r;
  logic [31:0]       mem_r [DEPTH_WORDS];

  logic              req_s;
  logic              busy_s;
  logic              enter_done_s;
  logic [IDX_W+1:0]  eff_addr_s;
  logic [31:0]       eff_wdata_s;
  logic [3:0]        eff_read_s;
  logic [2:0]        eff_write_s;
  logic              is_store_s;
  logic              is_load_s;
  logic [IDX_W-1:0]  word_idx_s;
  logic [31:0]       rword_s;
  logic [3:0]        byte_en_s;
  logic [31:0]       wdata_lanes_s;
  logic [31:0]       load_data_s;
  logic              misaligned_s;
  logic              unused_addr_s;

  assign req_s         = READ[READ_EN_BIT] | WRITE[WRITE_EN_BIT];
  assign unused_addr_s = ^ADDRESS[31:IDX_W+2];

  // Next state and BUSYWAIT; reset wins over everything and drops BUSYWAIT at once
  always_comb begin
    state_next_s = state_r;
    busy_s       = 1'b0;
    if (RST) begin
      state_next_s = IDLE;
      busy_s       = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          busy_s = req_s;
          if (req_s) begin
            state_next_s = AFTER_IDLE;
          end else begin
            state_next_s = IDLE;
          end
        end
        WAIT: begin
          busy_s = 1'b1;
          if (count_r == CNT_LAST) begin
            state_next_s = DONE;
          end else begin
            state_next_s = WAIT;
          end
        end
        DONE: begin
          busy_s       = 1'b0;
          state_next_s = IDLE;
        end
        default: begin
          busy_s       = 1'b0;
          state_next_s = IDLE;
        end
      endcase
    end
  end

  assign enter_done_s = (state_next_s == DONE);

  // Live inputs are used when the access completes straight out of IDLE
  always_comb begin
    if (state_r == IDLE) begin
      eff_addr_s  = ADDRESS[IDX_W+1:0];
      eff_wdata_s = WRITEDATA;
      eff_read_s  = READ;
      eff_write_s = WRITE;
    end else begin
      eff_addr_s  = addr_r;
      eff_wdata_s = wdata_r;
      eff_read_s  = read_r;
      eff_write_s = write_r;
    end
  end

  // A simultaneous load and store is serviced as the store alone
  assign is_store_s = eff_write_s[WRITE_EN_BIT];
  assign is_load_s  = eff_read_s[READ_EN_BIT] & ~is_store_s;
  assign word_idx_s = eff_addr_s[IDX_W+1:2];
  assign rword_s    = mem_r[word_idx_s];

  dmem_lane_align u_lane_align (
    .addr_lo     (eff_addr_s[1:0]),
    .wdata       (eff_wdata_s),
    .load_funct3 (eff_read_s[2:0]),
    .store_size  (eff_write_s[1:0]),
    .is_store    (is_store_s),
    .rword       (rword_s),
    .byte_en     (byte_en_s),
    .wdata_lanes (wdata_lanes_s),
    .load_data   (load_data_s),
    .misaligned  (misaligned_s)
  );

  // State register, latency counter and request capture
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= IDLE;
      count_r <= CNT_ZERO;
      addr_r  <= {(IDX_W + 2){1'b0}};
      wdata_r <= 32'h0000_0000;
      read_r  <= 4'b0000;
      write_r <= 3'b000;
    end else begin
      state_r <= state_next_s;
      if ((state_r == IDLE) && req_s) begin
        count_r <= CNT_ONE;
        addr_r  <= ADDRESS[IDX_W+1:0];
        wdata_r <= WRITEDATA;
        read_r  <= READ;
        write_r <= WRITE;
      end else if (state_r == WAIT) begin
        count_r <= count_r + CNT_ONE;
      end else begin
        count_r <= CNT_ZERO;
      end
    end
  end

  // Load result and misalignment flag are captured on entry to DONE
  always_ff @(posedge CLK) begin
    if (RST) begin
      readdata_r   <= 32'h0000_0000;
      misaligned_r <= 1'b0;
    end else begin
      misaligned_r <= enter_done_s ? misaligned_s : 1'b0;
      if (enter_done_s && is_load_s) begin
        readdata_r <= load_data_s;
      end
    end
  end

  // Byte-masked array write on entry to DONE; contents survive reset
  always_ff @(posedge CLK) begin
    if (enter_done_s && is_store_s) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en_s[i]) begin
          mem_r[word_idx_s][8*i +: 8] <= wdata_lanes_s[8*i +: 8];
        end
      end
    end
  end

  assign READDATA   = readdata_r;
  assign BUSYWAIT   = busy_s;
  assign MISALIGNED = misaligned_r;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed scoreboard bench for data_memory_ctrl: one instance with
// LATENCY=5 and one with LATENCY=1.
module tb_data_memory_ctrl;
  import dmem_pkg::*;

  logic        clk;
  logic        rst0, rst1;
  logic [31:0] addr0, addr1, wd0, wd1;
  logic [3:0]  rd0, rd1;
  logic [2:0]  wr0, wr1;
  logic [31:0] rdata0, rdata1;
  logic        bw0, bw1, mis0, mis1;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] rd;
    logic        mis;
    string       tag;
  } exp_t;
  exp_t sb_q[$];

  logic [31:0] last_rd0, last_rd1;

  data_memory_ctrl #(.DEPTH_WORDS(256), .LATENCY(5)) u_dut (
    .CLK(clk), .RST(rst0), .ADDRESS(addr0), .WRITEDATA(wd0), .READ(rd0),
    .WRITE(wr0), .READDATA(rdata0), .BUSYWAIT(bw0), .MISALIGNED(mis0)
  );

  data_memory_ctrl #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
    .CLK(clk), .RST(rst1), .ADDRESS(addr1), .WRITEDATA(wd1), .READ(rd1),
    .WRITE(wr1), .READDATA(rdata1), .BUSYWAIT(bw1), .MISALIGNED(mis1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One access on the selected instance: push expectation, drive, wait, pop, compare
  task automatic access(input bit sel, input logic [3:0] rd, input logic [2:0] wr,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input logic [31:0] exp_rd, input logic exp_mis,
                        input int exp_lat, input string tag);
    exp_t e;
    int   n;
    logic b;
    e.rd = exp_rd; e.mis = exp_mis; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk); #1;
    if (sel) begin
      rd1 = rd; wr1 = wr; addr1 = addr; wd1 = wd;
    end else begin
      rd0 = rd; wr0 = wr; addr0 = addr; wd0 = wd;
    end
    n = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      b = sel ? bw1 : bw0;
      if (!b) break;
      n++;
    end
    e = sb_q.pop_front();
    check({e.tag, "_latency"}, n, exp_lat);
    check({e.tag, "_readdata"}, sel ? rdata1 : rdata0, e.rd);
    check({e.tag, "_misaligned"}, {31'd0, sel ? mis1 : mis0}, {31'd0, e.mis});
    @(posedge clk); #1;
    if (sel) begin
      rd1 = 4'b0000; wr1 = 3'b000;
    end else begin
      rd0 = 4'b0000; wr0 = 3'b000;
    end
    @(negedge clk);
    check({e.tag, "_mis_pulse"}, {31'd0, sel ? mis1 : mis0}, 32'd0);
    check({e.tag, "_idle_busy"}, {31'd0, sel ? bw1 : bw0}, 32'd0);
  endtask

  task automatic load0(input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] exp, input logic exp_mis, input string tag);
    access(1'b0, {1'b1, f3}, 3'b000, addr, 32'h0, exp, exp_mis, 5, tag);
    last_rd0 = exp;
  endtask

  task automatic store0(input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input string tag);
    access(1'b0, 4'b0000, {1'b1, sz}, addr, wd, last_rd0, 1'b0, 5, tag);
  endtask

  initial begin
    rst0 = 1'b1; rst1 = 1'b1;
    addr0 = 32'h0; addr1 = 32'h0; wd0 = 32'h0; wd1 = 32'h0;
    rd0 = 4'b0000; rd1 = 4'b0000; wr0 = 3'b000; wr1 = 3'b000;
    last_rd0 = 32'h0; last_rd1 = 32'h0;

    // Reset then idle
    @(posedge clk); @(posedge clk); #1;
    @(negedge clk);
    check("rst_readdata", rdata0, 32'h0);
    check("rst_busy", {31'd0, bw0}, 32'd0);
    check("rst_mis", {31'd0, mis0}, 32'd0);
    @(posedge clk); #1;
    rst0 = 1'b0; rst1 = 1'b0;
    @(negedge clk);
    check("idle_readdata", rdata0, 32'h0);
    check("idle_busy", {31'd0, bw0}, 32'd0);
    check("idle1_readdata", rdata1, 32'h0);

    // Word round trip and extensions
    store0(SW, 32'h40, 32'hDEAD_BEEF, "sw_40");
    load0(LW,  32'h40, 32'hDEAD_BEEF, 1'b0, "lw_40");
    load0(LB,  32'h43, 32'hFFFF_FFDE, 1'b0, "lb_43");
    load0(LBU, 32'h43, 32'h0000_00DE, 1'b0, "lbu_43");
    load0(LH,  32'h40, 32'hFFFF_BEEF, 1'b0, "lh_40");
    load0(LHU, 32'h42, 32'h0000_DEAD, 1'b0, "lhu_42");

    // Partial stores
    store0(SB, 32'h41, 32'h0000_0012, "sb_41");
    load0(LW,  32'h40, 32'hDEAD_12EF, 1'b0, "lw_after_sb");
    store0(SH, 32'h42, 32'h0000_7777, "sh_42");
    load0(LW,  32'h40, 32'h7777_12EF, 1'b0, "lw_after_sh");

    // Misaligned and address wrap
    load0(LW,  32'h43, 32'h7777_12EF, 1'b1, "lw_mis_43");
    store0(SW, 32'h440, 32'h1111_1111, "sw_wrap_440");
    load0(LW,  32'h40, 32'h1111_1111, 1'b0, "lw_after_wrap");
    load0(LH,  32'h41, 32'h0000_1111, 1'b1, "lh_mis_41");
    load0(3'b011, 32'h40, 32'h1111_1111, 1'b0, "unsup_f3_lw");

    // Load and store together: only the store happens, READDATA holds
    access(1'b0, {1'b1, LBU}, {1'b1, SB}, 32'h40, 32'h0000_00AB,
           last_rd0, 1'b0, 5, "ld_st_both");
    load0(LW,  32'h40, 32'h1111_11AB, 1'b0, "lw_after_both");

    // Reset in the third busy cycle abandons the store
    store0(SW, 32'h80, 32'h0123_4567, "sw_80");
    @(posedge clk); #1;
    wr0 = {1'b1, SW}; addr0 = 32'h80; wd0 = 32'hCAFE_F00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_before_rst", {31'd0, bw0}, 32'd1);
    rst0 = 1'b1;
    #1;
    check("rst_drops_busy", {31'd0, bw0}, 32'd0);
    @(posedge clk); #1;
    rst0 = 1'b0; wr0 = 3'b000;
    @(negedge clk);
    check("after_abort_busy", {31'd0, bw0}, 32'd0);
    check("after_abort_readdata", rdata0, 32'h0);
    last_rd0 = 32'h0;
    load0(LW, 32'h80, 32'h0123_4567, 1'b0, "lw_80_old");

    // Single-cycle latency instance
    access(1'b1, 4'b0000, {1'b1, SW}, 32'h10, 32'h5A5A_3C3C, last_rd1, 1'b0, 1, "l1_sw");
    access(1'b1, {1'b1, LW}, 3'b000, 32'h10, 32'h0, 32'h5A5A_3C3C, 1'b0, 1, "l1_lw");
    last_rd1 = 32'h5A5A_3C3C;
    access(1'b1, {1'b1, LB}, 3'b000, 32'h13, 32'h0, 32'h0000_005A, 1'b0, 1, "l1_lb");
    last_rd1 = 32'h0000_005A;
    access(1'b1, {1'b1, LHU}, 3'b000, 32'h11, 32'h0, 32'h0000_3C3C, 1'b1, 1, "l1_lhu_mis");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
